// File: rtl/tnoc_pkg.sv
// Shared NoC package: configuration record and flit format.
// The arbiter and its output slice take the flit type and the head/tail
// fields from here; nothing block-specific lives in this package.
package tnoc_pkg;

    // NoC-wide configuration carried as a single parameter.
    typedef struct packed {
        int unsigned virtual_channels;
    } tnoc_config_t;

    localparam tnoc_config_t TNOC_DEFAULT_CONFIG = '{virtual_channels: 32'd2};

    localparam int unsigned TNOC_DATA_W = 32;

    // One flit: packet delimiters plus payload.
    typedef struct packed {
        logic                   head;
        logic                   tail;
        logic [TNOC_DATA_W-1:0] data;
    } tnoc_flit_t;

endpackage

// File: rtl/tnoc_flit_if.sv
// Flit link: per-VC valid/ready/vc_available plus one flit payload.
//   initiator : drives valid, flit;        receives ready, vc_available
//   target    : receives valid, flit;      drives ready, vc_available
interface tnoc_flit_if
    import tnoc_pkg::*;
#(
    parameter int unsigned CHANNELS = 2
) ();

    logic [CHANNELS-1:0] valid;
    logic [CHANNELS-1:0] ready;
    logic [CHANNELS-1:0] vc_available;
    tnoc_flit_t          flit;

    modport initiator (output valid, output flit, input ready, input vc_available);
    modport target    (input valid, input flit, output ready, output vc_available);

endinterface

// File: rtl/tnoc_flit_slice.sv
// Two-entry flit skid buffer: one cycle of latency, one flit per cycle.
// Ports:
//   clk_i, rst_ni       clock, asynchronous active-low reset
//   valid_i, flit_i     upstream per-VC valid and flit
//   ready_o             upstream per-VC ready (buffer not full)
//   valid_o, flit_o     downstream per-VC valid and flit
//   ready_i             downstream per-VC ready
module tnoc_flit_slice
    import tnoc_pkg::*;
#(
    parameter int unsigned CHANNELS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [CHANNELS-1:0] valid_i,
    input  tnoc_flit_t          flit_i,
    output logic [CHANNELS-1:0] ready_o,
    output logic [CHANNELS-1:0] valid_o,
    output tnoc_flit_t          flit_o,
    input  logic [CHANNELS-1:0] ready_i
);

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CNT_W = 2;

    logic [DEPTH-1:0][CHANNELS-1:0] vc_q, vc_d;
    tnoc_flit_t [DEPTH-1:0]         flit_q, flit_d;
    logic                           wr_ptr_q, wr_ptr_d;
    logic                           rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]               count_q, count_d;
    logic                           push;
    logic                           pop;

    // Each entry keeps the VC mask it arrived on.
    assign ready_o = (count_q == CNT_W'(DEPTH)) ? '0 : '1;
    assign valid_o = (count_q == '0) ? '0 : vc_q[rd_ptr_q];
    assign flit_o  = flit_q[rd_ptr_q];

    assign push = |(valid_i & ready_o);
    assign pop  = |(valid_o & ready_i);

    // Next-state for storage, pointers and occupancy.
    always_comb begin : slice_next
        vc_d     = vc_q;
        flit_d   = flit_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            vc_d[wr_ptr_q]   = valid_i;
            flit_d[wr_ptr_q] = flit_i;
            wr_ptr_d         = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    // Storage and pointer registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin : slice_regs
        if (!rst_ni) begin
            vc_q     <= '0;
            flit_q   <= '0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
        end else begin
            vc_q     <= vc_d;
            flit_q   <= flit_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/tnoc_flit_arbiter.sv
// Packet-level round-robin arbiter merging ENTRIES flit links into one.
// A packet, once its head transfers, keeps the grant until its tail.
// Optional feature macro: TNOC_FLIT_ARBITER_OUTPUT_SLICE_EN inserts a
// tnoc_flit_slice on the merged output (one cycle latency, full rate).
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   flit_in_if[]     per-entry target links (valid/flit in, ready/vc_available out)
//   flit_out_if      merged initiator link
//   o_grant          one-hot current grant, zero when nothing is granted
module tnoc_flit_arbiter
    import tnoc_pkg::*;
#(
    parameter tnoc_config_t CONFIG   = TNOC_DEFAULT_CONFIG,
    parameter int unsigned  CHANNELS = CONFIG.virtual_channels,
    parameter int unsigned  ENTRIES  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    tnoc_flit_if.target        flit_in_if [ENTRIES],
    tnoc_flit_if.initiator     flit_out_if,
    output logic [ENTRIES-1:0] o_grant
);

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } state_e;

    localparam int unsigned IDX_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

    state_e                           state_q, state_d;
    logic [ENTRIES-1:0]               grant_q, grant_d;
    logic [IDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
    logic [ENTRIES-1:0]               req;
    logic [ENTRIES-1:0]               rr_grant;
    logic [ENTRIES-1:0]               grant_c;
    logic [IDX_W-1:0]                 grant_idx;
    logic [ENTRIES-1:0][CHANNELS-1:0] in_valid;
    tnoc_flit_t [ENTRIES-1:0]         in_flit;
    logic [CHANNELS-1:0]              arb_valid;
    tnoc_flit_t                       arb_flit;
    logic [CHANNELS-1:0]              arb_ready;
    logic                             xfer;

    // Flatten the interface array; ready goes only to the granted entry.
    for (genvar i = 0; i < ENTRIES; i++) begin : g_entry
        assign in_valid[i]                = flit_in_if[i].valid;
        assign in_flit[i]                 = flit_in_if[i].flit;
        assign req[i]                     = |in_valid[i];
        assign flit_in_if[i].ready        = grant_c[i] ? arb_ready : '0;
        assign flit_in_if[i].vc_available = flit_out_if.vc_available;
    end

    // First requester at or after rr_ptr, wrapping modulo ENTRIES.
    always_comb begin : rr_pick
        int unsigned idx;
        logic        found;
        rr_grant = '0;
        found    = 1'b0;
        idx      = 0;
        for (int unsigned k = 0; k < ENTRIES; k++) begin
            idx = 32'(rr_ptr_q) + k;
            if (idx >= ENTRIES) begin
                idx = idx - ENTRIES;
            end
            if (!found && req[IDX_W'(idx)]) begin
                rr_grant[IDX_W'(idx)] = 1'b1;
                found                 = 1'b1;
            end
        end
    end

    // Reset masks the grant so nothing leaks out while rst is low.
    always_comb begin : grant_sel
        grant_c = '0;
        if (i_rst_n) begin
            grant_c = (state_q == LOCKED) ? grant_q : rr_grant;
        end
    end

    always_comb begin : grant_encode
        grant_idx = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (grant_c[i]) begin
                grant_idx = IDX_W'(i);
            end
        end
    end

    assign o_grant   = grant_c;
    assign arb_valid = (|grant_c) ? in_valid[grant_idx] : '0;
    assign arb_flit  = in_flit[grant_idx];
    assign xfer      = |(arb_valid & arb_ready);

`ifdef TNOC_FLIT_ARBITER_OUTPUT_SLICE_EN
    // Lock and rr_ptr follow transfers into the slice, not out of it.
    tnoc_flit_slice #(
        .CHANNELS (CHANNELS)
    ) u_slice (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .valid_i (arb_valid),
        .flit_i  (arb_flit),
        .ready_o (arb_ready),
        .valid_o (flit_out_if.valid),
        .flit_o  (flit_out_if.flit),
        .ready_i (flit_out_if.ready)
    );
`else
    assign flit_out_if.valid = arb_valid;
    assign flit_out_if.flit  = arb_flit;
    assign arb_ready         = flit_out_if.ready;
`endif

    // Lock on a multi-flit head, release on tail; a head+tail flit stays IDLE.
    always_comb begin : fsm_next
        state_d  = state_q;
        grant_d  = grant_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            IDLE: begin
                if (xfer && arb_flit.head && !arb_flit.tail) begin
                    state_d = LOCKED;
                    grant_d = grant_c;
                end
            end
            LOCKED: begin
                if (xfer && arb_flit.tail) begin
                    state_d = IDLE;
                    grant_d = '0;
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
        if (xfer && arb_flit.tail) begin
            rr_ptr_d = (grant_idx == IDX_W'(ENTRIES - 1)) ? '0 : grant_idx + IDX_W'(1);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin : fsm_regs
        if (!i_rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

endmodule

// File: doc/tnoc_flit_arbiter.md
TNOC_FLIT_ARBITER -- requirements
Module: tnoc_flit_arbiter

Interface
REQ-001 SHALL have parameter CONFIG, default TNOC_DEFAULT_CONFIG: NoC configuration (flit format, virtual channels).
REQ-002 SHALL have parameter CHANNELS, default CONFIG.virtual_channels: virtual channels per flit interface.
REQ-003 SHALL have parameter ENTRIES, default 2: number of input flit interfaces (legal range 2..16).
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port i_rst_n, input, 1: reset, asynchronous assert, active-low.
REQ-006 SHALL have port flit_in_if, tnoc_flit_if.target array [ENTRIES]: valid/flit in, ready/vc_available out, per entry.
REQ-007 SHALL have port flit_out_if, tnoc_flit_if.initiator: merged output; valid/flit out, ready/vc_available in.
REQ-008 SHALL have port o_grant, output, ENTRIES: one-hot current grant, all-zero when nothing is granted.

Function
REQ-009 SHALL treat entry i as requesting when any bit of flit_in_if[i].valid is 1.
REQ-010 SHALL transfer a flit on VC c when valid[c] and ready[c] are both 1 on the same edge.
REQ-011 SHALL use FSM states IDLE and LOCKED.
REQ-012 SHALL, in IDLE, grant combinationally the first requester at or after rr_ptr (round robin, modulo ENTRIES), same cycle.
REQ-013 SHALL go IDLE->LOCKED on a transferred head flit with tail=0 and hold the grant register at that entry.
REQ-014 SHALL, in LOCKED, keep the grant on the locked entry regardless of other requests, including cycles where the locked entry is idle.
REQ-015 SHALL go LOCKED->IDLE on a transferred flit with tail=1; a head+tail flit in IDLE SHALL not change state.
REQ-016 SHALL set rr_ptr to (granted index+1) mod ENTRIES on every transferred tail flit, wrapping from ENTRIES-1 to 0.
REQ-017 SHALL drive the output valid and flit from the granted entry only; valid SHALL be 0 when there is no grant.
REQ-018 SHALL route the output ready only to the granted entry; non-granted entries SHALL see ready=0.
REQ-019 SHALL broadcast the output vc_available to every entry.
REQ-020 SHALL, when valid and ready are simultaneous with a new request on another entry, grant that entry only after the tail transfers (no mid-packet switch).
REQ-021 SHALL sustain one flit per cycle, including tail-to-head hand-over between entries with no bubble.

Reset
REQ-022 SHALL, on i_rst_n=0, asynchronously force state=IDLE, rr_ptr=0, grant register=0, o_grant=0, output valid=0, all input ready=0.
REQ-023 SHALL abandon an in-flight packet on reset and resume normal arbitration on the first edge after release.

Configuration
REQ-024 SHALL, with TNOC_FLIT_ARBITER_OUTPUT_SLICE_EN defined, insert a 2-entry output skid buffer: 1-cycle added latency, full throughput, input ready = buffer not full.
REQ-025 SHALL, without TNOC_FLIT_ARBITER_OUTPUT_SLICE_EN, connect valid, flit and ready combinationally with zero latency.
REQ-026 SHALL evaluate lock and rr_ptr updates on transfers into the slice when the slice is enabled.

Structure
REQ-027 SHALL take the flit typedef and head/tail field definitions from the shared tnoc package; no new package types.
REQ-028 SHALL place the FSM, grant register and rr_ptr in the top module.
REQ-029 SHALL implement the output slice as sub-module tnoc_flit_slice, reusable elsewhere.

Verification
REQ-030 SHALL cover: reset, then entries 0 and 1 both send 1-flit packets each cycle -> grants alternate 0,1,0,1 with no idle cycle.
REQ-031 SHALL cover: entry 1 sends a 4-flit packet (head, 2 body, tail) while entry 0 requests at cycle 1 -> entry 0 is granted only on the cycle after entry 1's tail.
REQ-032 SHALL cover: output ready=0 for 3 cycles mid-packet -> flit held stable, grant unchanged, no flit dropped.
REQ-033 SHALL cover: ENTRIES=4, rr_ptr=3, requests from 3 and 0 -> 3 first, then 0 (wrap).
REQ-034 SHALL cover: i_rst_n low after the second flit of a 4-flit packet -> state IDLE, rr_ptr=0, all outputs 0 next.
REQ-035 SHALL cover: with the slice macro, a 1-flit packet appears at the output exactly one cycle after input acceptance; back-to-back stream shows 100% throughput.
